// File: rtl/sram_bist_pkg.sv
// Shared types and per-element constant table for the March C- BIST sequencer.
package sram_bist_pkg;

  typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_t;
  typedef enum logic {OP_R, OP_W} op_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Every two-op element is (read, write) at the same address.
  localparam op_t SECOND_OP = OP_W;

  typedef struct packed {
    logic two_op;   // element has a read followed by a write
    op_t  first_op; // operation issued at phase 0
    logic rd_inv;   // read expects ~BG
    logic wr_inv;   // write stores ~BG
    logic down;     // address runs from the top word downwards
  } elem_cfg_t;

  function automatic elem_cfg_t elem_cfg(elem_t e);
    elem_cfg_t c;
    c = '{two_op: 1'b0, first_op: OP_R, rd_inv: 1'b0, wr_inv: 1'b0, down: 1'b0};
    unique case (e)
      E0:      c = '{two_op: 1'b0, first_op: OP_W, rd_inv: 1'b0, wr_inv: 1'b0, down: 1'b0};
      E1:      c = '{two_op: 1'b1, first_op: OP_R, rd_inv: 1'b0, wr_inv: 1'b1, down: 1'b0};
      E2:      c = '{two_op: 1'b1, first_op: OP_R, rd_inv: 1'b1, wr_inv: 1'b0, down: 1'b0};
      E3:      c = '{two_op: 1'b1, first_op: OP_R, rd_inv: 1'b0, wr_inv: 1'b1, down: 1'b1};
      E4:      c = '{two_op: 1'b1, first_op: OP_R, rd_inv: 1'b1, wr_inv: 1'b0, down: 1'b1};
      E5:      c = '{two_op: 1'b0, first_op: OP_R, rd_inv: 1'b0, wr_inv: 1'b0, down: 1'b0};
      default: c = '{two_op: 1'b0, first_op: OP_R, rd_inv: 1'b0, wr_inv: 1'b0, down: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sram_bist_march_ctrl_if.sv
// BIST-side pin bundle between the sequencer (master) and the SRAM macro (slave).
interface sram_bist_march_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              bist_en;
  logic              bist_men;
  logic              bist_wen;
  logic              bist_ren;
  logic [ADDR_W-1:0] bist_addr;
  logic [DATA_W-1:0] bist_din;
  logic [DATA_W-1:0] bist_bm;
  logic [DATA_W-1:0] sram_dout;

  modport master (
    output bist_en, bist_men, bist_wen, bist_ren, bist_addr, bist_din, bist_bm,
    input  sram_dout
  );

  modport slave (
    input  bist_en, bist_men, bist_wen, bist_ren, bist_addr, bist_din, bist_bm,
    output sram_dout
  );
endinterface

// File: rtl/sram_bist_cmp.sv
// One-stage read-compare pipeline with first-fail capture and saturating error count.
module sram_bist_cmp
  import sram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,     // new test accepted
  input  logic              flush,     // abort: drop anything in flight
  input  logic              rd_valid,  // read on the bus this cycle
  input  logic [DATA_W-1:0] rd_exp,
  input  logic [ADDR_W-1:0] rd_addr,
  input  elem_t             rd_elem,
  input  logic [DATA_W-1:0] sram_dout,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data
);

  logic              pend_q;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] paddr_q;
  elem_t             pelem_q;
  logic              mismatch;

  logic [7:0]        err_cnt_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [2:0]        fail_elem_q;
  logic [DATA_W-1:0] fail_data_q;

  // Carry the read's expectation one cycle to line up with DOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 1'b0;
      exp_q   <= '0;
      paddr_q <= '0;
      pelem_q <= E0;
    end else begin
      pend_q  <= rd_valid && !flush && !clear;
      exp_q   <= rd_exp;
      paddr_q <= rd_addr;
      pelem_q <= rd_elem;
    end
  end

  assign mismatch = pend_q && !flush && (sram_dout != exp_q);

  // Count mismatches; capture diagnostics only for the first one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_data_q <= '0;
    end else if (clear) begin
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_data_q <= '0;
    end else if (mismatch) begin
      if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      if (err_cnt_q == 8'h00) begin
        fail_addr_q <= paddr_q;
        fail_elem_q <= pelem_q;
        fail_data_q <= sram_dout;
      end
    end
  end

  assign err_cnt   = err_cnt_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign fail_data = fail_data_q;

endmodule

// File: rtl/sram_bist_march_ctrl.sv
// March C- BIST sequencer: FSM plus element/address counters driving the macro BIST port.
module sram_bist_march_ctrl
  import sram_bist_pkg::*;
#(
  parameter int unsigned     ADDR_W = 8,
  parameter int unsigned     DATA_W = 8,
  parameter logic [DATA_W-1:0] BG   = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  sram_bist_march_ctrl_if.master mem,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [7:0]             err_cnt,
  output logic [ADDR_W-1:0]      fail_addr,
  output logic [2:0]             fail_elem,
  output logic [DATA_W-1:0]      fail_data
);

  localparam logic [ADDR_W-1:0] TopAddr = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  elem_t             elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;
  logic              start_acc;
  elem_cfg_t         cfg_q, cfg_d;
  op_t               op_d;

  logic              en_q, men_q, wen_q, ren_q;
  logic              en_d, men_d, wen_d, ren_d;
  logic [ADDR_W-1:0] baddr_q, baddr_d;
  logic [DATA_W-1:0] din_q, din_d, bm_q, bm_d;
  logic              pass_q;

  assign cfg_q = elem_cfg(elem_q);

  // Next-state: walk phase, then address, then element; abort always wins.
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    addr_d    = addr_q;
    phase_d   = phase_q;
    start_acc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          start_acc = 1'b1;
          state_d   = RUN;
          elem_d    = E0;
          addr_d    = '0;
          phase_d   = 1'b0;
        end
      end
      RUN: begin
        if (!phase_q && cfg_q.two_op) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (addr_q == (cfg_q.down ? '0 : TopAddr)) begin
            if (elem_q == E5) begin
              state_d = DRAIN;
            end else begin
              elem_d = elem_t'(elem_q + 3'd1);
              addr_d = elem_cfg(elem_d).down ? TopAddr : '0;
            end
          end else begin
            addr_d = cfg_q.down ? addr_q - 1'b1 : addr_q + 1'b1;
          end
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Bus values for the operation that will be on the pins next cycle.
  always_comb begin
    cfg_d   = elem_cfg(elem_d);
    op_d    = phase_d ? SECOND_OP : cfg_d.first_op;
    men_d   = (state_d == RUN);
    en_d    = men_d || (state_d == DRAIN);
    wen_d   = men_d && (op_d == OP_W);
    ren_d   = men_d && (op_d == OP_R);
    din_d   = wen_d ? (cfg_d.wr_inv ? ~BG : BG) : '0;
    bm_d    = men_d ? '1 : '0;
    baddr_d = men_d ? addr_d : '0;
  end

  // FSM, counters and registered BIST pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      elem_q  <= E0;
      addr_q  <= '0;
      phase_q <= 1'b0;
      en_q    <= 1'b0;
      men_q   <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      baddr_q <= '0;
      din_q   <= '0;
      bm_q    <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      en_q    <= en_d;
      men_q   <= men_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      baddr_q <= baddr_d;
      din_q   <= din_d;
      bm_q    <= bm_d;
    end
  end

  // Verdict is latched on leaving DONE and held until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= 1'b0;
    end else if (start_acc) begin
      pass_q <= 1'b0;
    end else if (state_q == DONE && !abort) begin
      pass_q <= (err_cnt == 8'h00);
    end
  end

  sram_bist_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_acc),
    .flush     (abort),
    .rd_valid  (ren_q),
    .rd_exp    (cfg_q.rd_inv ? ~BG : BG),
    .rd_addr   (baddr_q),
    .rd_elem   (elem_q),
    .sram_dout (mem.sram_dout),
    .err_cnt   (err_cnt),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_data (fail_data)
  );

  assign mem.bist_en   = en_q;
  assign mem.bist_men  = men_q;
  assign mem.bist_wen  = wen_q;
  assign mem.bist_ren  = ren_q;
  assign mem.bist_addr = baddr_q;
  assign mem.bist_din  = din_q;
  assign mem.bist_bm   = bm_q;

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);
  assign pass = pass_q;

endmodule

// File: tb/tb_sram_bist_march_ctrl.sv
// Bench for the March C- sequencer: behavioural SRAM with injectable faults, an op scoreboard
// filled from the March C- definition, and a table of full-test scenarios.
module tb_sram_bist_march_ctrl;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int          NW    = 256;
  localparam int          NOPS  = 10 * NW;
  localparam int          RUNK  = NOPS + 40;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done, pass;
  logic [7:0]    err_cnt;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_data;

  sram_bist_march_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  sram_bist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BG(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .mem       (mem_if),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_data (fail_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural macro: byte-masked write, one-cycle registered read, optional fault.
  logic [7:0] marr [NW];
  int         fault = 0;

  function automatic logic [7:0] model_read(input logic [7:0] a);
    logic [7:0] v;
    v = marr[a];
    if (fault == 1 && a == 8'h2A) v = v | 8'h08;
    if (fault == 2) v = ~v;
    return v;
  endfunction

  always @(posedge clk) begin
    if (mem_if.bist_men && mem_if.bist_wen)
      marr[mem_if.bist_addr] <= (marr[mem_if.bist_addr] & ~mem_if.bist_bm) |
                                (mem_if.bist_din & mem_if.bist_bm);
    if (mem_if.bist_men && mem_if.bist_ren)
      mem_if.sram_dout <= model_read(mem_if.bist_addr);
  end

  // Scoreboard of expected memory operations.
  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] din;
  } sb_op_t;
  sb_op_t sb_q[$];

  task automatic push_march();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < NW; i++) begin
        logic [7:0] a;
        logic [7:0] wd;
        a  = (e == 3 || e == 4) ? 8'(NW - 1 - i) : 8'(i);
        wd = (e % 2 == 1) ? 8'hFF : 8'h00;
        if (e != 0) sb_q.push_back('{wr: 1'b0, addr: a, din: 8'h00});
        if (e != 5) sb_q.push_back('{wr: 1'b1, addr: a, din: wd});
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_if.bist_men === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL op_extra: got op at addr %0h, expected no op", mem_if.bist_addr);
      end else begin
        sb_op_t x;
        x = sb_q.pop_front();
        check("bus_op",
              {5'd0, mem_if.bist_en, mem_if.bist_wen, mem_if.bist_ren, mem_if.bist_addr,
               (mem_if.bist_wen ? mem_if.bist_din : 8'h00), mem_if.bist_bm},
              {5'd0, 1'b1, x.wr, ~x.wr, x.addr, (x.wr ? x.din : 8'h00), 8'hFF});
      end
    end
  end

  typedef struct {
    int   fault;
    int   abort_at;
    int   xs1;
    int   xs2;
    logic exp_pass;
    int   exp_err;
    int   exp_faddr;
    int   exp_felem;
    int   exp_fdata;
    logic exp_done;
  } vec_t;
  vec_t vecs[6];

  // One full scenario; cycle k of the loop is cycle E0+k.
  task automatic run_vec(input vec_t v, input int idx);
    int   ndone;
    int   done_at;
    int   busy_bad;
    int   busy_end;
    logic exp_busy;
    ndone    = 0;
    done_at  = -1;
    busy_bad = 0;
    busy_end = (v.abort_at > 0) ? v.abort_at : NOPS + 1;
    fault    = v.fault;
    sb_q.delete();
    push_march();
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= RUNK; k++) begin
      @(negedge clk);
      exp_busy = (k <= busy_end);
      if (busy !== exp_busy) busy_bad++;
      if (done === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      if (v.abort_at > 0 && k == v.abort_at + 1)
        check($sformatf("v%0d_abort_en_busy", idx), {mem_if.bist_en, busy, done}, 0);
      start = (k == v.xs1) || (k == v.xs2);
      abort = (v.abort_at > 0) && (k == v.abort_at);
    end
    start = 1'b0;
    abort = 1'b0;
    check($sformatf("v%0d_busy_profile_errs", idx), busy_bad, 0);
    check($sformatf("v%0d_done_count", idx), ndone, v.exp_done ? 1 : 0);
    if (v.exp_done) check($sformatf("v%0d_done_cycle", idx), done_at, NOPS + 2);
    else            check($sformatf("v%0d_sb_left_after_abort", idx), sb_q.size() > 0, 1);
    if (v.exp_done) check($sformatf("v%0d_sb_empty", idx), sb_q.size(), 0);
    check($sformatf("v%0d_pass", idx), pass, v.exp_pass);
    check($sformatf("v%0d_err_cnt", idx), err_cnt, v.exp_err);
    check($sformatf("v%0d_fail_addr", idx), fail_addr, v.exp_faddr);
    check($sformatf("v%0d_fail_elem", idx), fail_elem, v.exp_felem);
    check($sformatf("v%0d_fail_data", idx), fail_data, v.exp_fdata);
    sb_q.delete();
  endtask

  initial begin
    vecs[0] = '{fault: 0, abort_at: 0, xs1: 0, xs2: 0, exp_pass: 1'b1, exp_err: 0,
                exp_faddr: 0, exp_felem: 0, exp_fdata: 0, exp_done: 1'b1};
    vecs[1] = '{fault: 1, abort_at: 0, xs1: 0, xs2: 0, exp_pass: 1'b0, exp_err: 3,
                exp_faddr: 'h2A, exp_felem: 1, exp_fdata: 'h08, exp_done: 1'b1};
    vecs[2] = '{fault: 2, abort_at: 0, xs1: 0, xs2: 0, exp_pass: 1'b0, exp_err: 255,
                exp_faddr: 0, exp_felem: 1, exp_fdata: 'hFF, exp_done: 1'b1};
    vecs[3] = '{fault: 0, abort_at: 700, xs1: 0, xs2: 0, exp_pass: 1'b0, exp_err: 0,
                exp_faddr: 0, exp_felem: 0, exp_fdata: 0, exp_done: 1'b0};
    vecs[4] = '{fault: 0, abort_at: 0, xs1: 0, xs2: 0, exp_pass: 1'b1, exp_err: 0,
                exp_faddr: 0, exp_felem: 0, exp_fdata: 0, exp_done: 1'b1};
    vecs[5] = '{fault: 0, abort_at: 0, xs1: 5, xs2: 2000, exp_pass: 1'b1, exp_err: 0,
                exp_faddr: 0, exp_felem: 0, exp_fdata: 0, exp_done: 1'b1};

    #1 rst_n = 1'b0;
    #1;
    check("reset_status", {busy, done, pass, err_cnt, fail_addr, fail_elem, fail_data}, 0);
    check("reset_bus", {mem_if.bist_en, mem_if.bist_men, mem_if.bist_wen, mem_if.bist_ren,
                        mem_if.bist_addr, mem_if.bist_din, mem_if.bist_bm}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i);
      if (i == 2) begin
        // start and abort together in IDLE: abort wins, diagnostics are not cleared
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", {busy, mem_if.bist_en}, 0);
        check("abort_start_err_held", err_cnt, 255);
        check("abort_start_felem_held", fail_elem, 1);
        @(negedge clk);
        check("abort_start_still_idle", busy, 0);
      end
    end

    // Asynchronous reset in the middle of a faulty run
    fault = 1;
    sb_q.delete();
    push_march();
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k < 1000; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_reset_err_cnt", err_cnt, 1);
    check("pre_reset_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_status", {busy, done, pass, err_cnt, fail_addr, fail_elem, fail_data}, 0);
    check("midrst_bus", {mem_if.bist_en, mem_if.bist_men, mem_if.bist_wen, mem_if.bist_ren,
                         mem_if.bist_addr, mem_if.bist_din, mem_if.bist_bm}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("post_reset_idle", {busy, done, mem_if.bist_en}, 0);
    run_vec(vecs[0], 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_bist_march_ctrl.md
Name: sram_bist_march_ctrl

Overview:
- March C- BIST sequencer for the 256x8 single-port SRAM macro with byte mask and BIST port.
- Drives the macro's BIST-side pins (BIST_EN/MEN/WEN/REN/ADDR/DIN/BM) and checks the macro's DOUT.
- Reports pass/fail plus first-failure diagnostics.
- Sits next to the macro and is started by the SoC test/config block.

Parameters:
- ADDR_W, 8, address width; the array has 2**ADDR_W words.
- DATA_W, 8, data and byte-mask width.
- BG, 8'h00, background pattern; "0" = BG, "1" = ~BG.

Ports:
- clk  in  1  clock, shared with the macro's BIST_CLK.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  single-cycle pulse; honoured only in IDLE.
- abort  in  1  synchronous; returns to IDLE from any state.
- sram_dout  in  DATA_W  macro DOUT.
- bist_en  out  1  drives the macro's BIST_EN.
- bist_men  out  1  drives the macro's BIST_MEN.
- bist_wen  out  1  drives the macro's BIST_WEN.
- bist_ren  out  1  drives the macro's BIST_REN.
- bist_addr  out  ADDR_W  drives the macro's BIST_ADDR.
- bist_din  out  DATA_W  drives the macro's BIST_DIN.
- bist_bm  out  DATA_W  drives the macro's BIST_BM.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- pass  out  1  valid after done; held until the next start.
- err_cnt  out  8  saturating mismatch count.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_elem  out  3  march element of the first mismatch.
- fail_data  out  DATA_W  DOUT value at the first mismatch.

Behaviour:
- Reset: all outputs 0; state IDLE; diagnostics cleared.
- All bist_* outputs are registered.
- March elements, with elem index = fail_elem encoding:
  - E0 ⇕(w0)
  - E1 ⇑(r0,w1)
  - E2 ⇑(r1,w0)
  - E3 ⇓(r0,w1)
  - E4 ⇓(r1,w0)
  - E5 ⇕(r0)
- Address order: ⇕ and ⇑ run 0→2**ADDR_W-1; ⇓ runs 2**ADDR_W-1→0.
- States: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE:
  - start=1 at an edge E0 clears err_cnt, fail_*, pass.
  - Moves to RUN with elem=0, addr=0, phase=first op.
- RUN:
  - One memory operation per cycle; bist_en=bist_men=1; bist_bm all-ones.
  - Read: ren=1, wen=0. Write: wen=1, ren=0, din=BG or ~BG.
  - Two-op elements alternate phase R then W at the same address, then advance the address.
  - At the last address of an element, move to the next element at its start address.
  - After the last E5 read, move to DRAIN.
- Read latency is 1:
  - A read issued in cycle t is compared against sram_dout in cycle t+1.
  - Expected value, address and elem are pipelined one stage alongside it.
- DRAIN: bist_en=1, bist_men=0; compares the final read.
- DONE: done=1 for one cycle; busy=0; pass=(err_cnt==0) latched; next state IDLE.
- Timing: 10*2**ADDR_W operation cycles after E0. For the defaults, done is high in cycle E0+2562; busy is high in cycles E0+1..E0+2561.
- Mismatch:
  - err_cnt increments, saturating at 255.
  - fail_addr, fail_elem and fail_data are captured only on the first mismatch.
  - The test continues to completion.
- Reads are never issued to an unwritten word; E0 has no compare.
- start while busy: ignored.
- abort:
  - Next cycle is IDLE; bist_* forced to 0; no done.
  - pass stays 0; err_cnt and fail_* hold their last values.
- abort and start in the same cycle in IDLE: abort wins.
- A pending compare in flight during abort is discarded.
- rst_n low mid-test: immediately clears everything; the macro is left with no active strobe.

Decomposition:
- Shared package sram_bist_pkg:
  - march-element enum (E0..E5).
  - op enum (OP_R, OP_W).
  - state enum (IDLE, RUN, DRAIN, DONE).
  - per-element constant tables: op count, first/second op, expected/written polarity, direction.
- Sub-module sram_bist_cmp:
  - the one-stage compare pipeline.
  - first-fail capture and the saturating counter.
- The top holds the FSM and the address/element counters.

Test Plan:
- Ideal memory model, start pulse → busy for 2561 cycles; done at E0+2562; pass=1; err_cnt=0. Exactly 256 writes of 8'h00 in E0; in E3 the addr sequence is 255,255,254,254,…
- Model with a stuck-at-1 on bit 3 at addr 8'h2A → pass=0; fail_addr=8'h2A; fail_elem=1; fail_data=8'h08.
  - E3 also mismatches there, but the first-fail fields are unchanged.
  - err_cnt=3 (E1 r0, E3 r0, E5 r0).
- Model flipping all reads to ~expected → err_cnt saturates at 255; fail_addr=0; fail_elem=1; fail_data=8'hFF.
- abort asserted at E0+700 → bist_en=0 next cycle; no done; busy=0. A new start then runs a clean full test with pass=1.
- rst_n low at E0+1000 for 2 cycles → all outputs 0 asynchronously (checked mid-cycle); FSM in IDLE; start reissued completes normally.
- start pulses at E0+5 and E0+2000 → ignored; exactly one done, still at E0+2562.
